// File: rtl/fsmc_pkg.sv
// ============================================================================
// Module      : fsmc_pkg
// Description : Shared types and constants for the FSMC slave front end.
//               Defines the front-end state encoding, the word driven onto
//               the bus when a read times out, and the default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsmc_pkg;

  localparam int FSMC_DATA_W = 16;
  localparam int FSMC_ADDR_W = 2;

  // Word returned to the MCU when downstream fails to acknowledge a read
  localparam logic [15:0] FSMC_ERR_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_DRIVE = 3'd3,
    ST_ERR      = 3'd4
  } fsmc_state_t;

endpackage : fsmc_pkg

`default_nettype wire

// File: rtl/fsmc_bus_frontend_if.sv
// ============================================================================
// Module      : fsmc_bus_frontend_if
// Description : Handshake between the FSMC front end and the buffer stage.
//               master : front end  (drives wr_stb/wr_addr/wr_data,
//                                    rd_req/rd_addr; receives rd_data/rd_ack)
//               slave  : buffer stage (the mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsmc_bus_frontend_if
  import fsmc_pkg::*;
#(
  parameter int DATA_W = FSMC_DATA_W,
  parameter int ADDR_W = FSMC_ADDR_W
) ();

  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ack;

  modport master (
    output wr_stb, wr_addr, wr_data, rd_req, rd_addr,
    input  rd_data, rd_ack
  );

  modport slave (
    input  wr_stb, wr_addr, wr_data, rd_req, rd_addr,
    output rd_data, rd_ack
  );

endinterface : fsmc_bus_frontend_if

`default_nettype wire

// File: rtl/fsmc_sync.sv
// ============================================================================
// Module      : fsmc_sync
// Description : N-stage single-bit synchroniser. All stages reset to 1 so
//               that active-low bus strobes read as inactive out of reset.
//   clk     in  system clock
//   reset_l in  async active-low reset
//   d       in  asynchronous input
//   q       out synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsmc_sync #(
  parameter int STAGES = 2
) (
  input  wire  clk,
  input  wire  reset_l,
  input  wire  d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule : fsmc_sync

`default_nettype wire

// File: rtl/fsmc_bus_frontend.sv
// ============================================================================
// Module      : fsmc_bus_frontend
// Description : STM32 FSMC slave front end. Synchronises noe/nwe/ncs into
//               clk, turns each bus cycle into a one-cycle write strobe or a
//               read request/acknowledge handshake, and owns the tristate
//               data bus.
//   clk, reset_l        clock, async active-low reset
//   noe, nwe, ncs, addr asynchronous FSMC pins
//   data                FSMC tristate data bus
//   dn                  handshake to the buffer stage (master side)
//   busy                state is not IDLE
//   err_stb             one-cycle protocol/timeout error pulse
//   wr_cnt/rd_cnt/err_cnt statistics counters
// Optional feature : FSMC_STATS_EN - when defined, the three counters count
//               wr_stb/rd_req/err_stb (16-bit, wrapping); otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsmc_bus_frontend
  import fsmc_pkg::*;
#(
  parameter int DATA_W      = FSMC_DATA_W,
  parameter int ADDR_W      = FSMC_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 8
) (
  input  wire                clk,
  input  wire                reset_l,
  input  wire                noe,
  input  wire                nwe,
  input  wire                ncs,
  input  wire  [ADDR_W-1:0]  addr,
  inout  wire  [DATA_W-1:0]  data,
  fsmc_bus_frontend_if.master dn,
  output logic               busy,
  output logic               err_stb,
  output logic [15:0]        wr_cnt,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        err_cnt
);

  localparam int TMO_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

  // --------------------------------------------------------------------------
  // Pin synchronisers and aligned address/data pipeline
  // --------------------------------------------------------------------------
  logic w_noe_s, w_nwe_s, w_ncs_s;

  fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_noe (
    .clk(clk), .reset_l(reset_l), .d(noe), .q(w_noe_s));
  fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_nwe (
    .clk(clk), .reset_l(reset_l), .d(nwe), .q(w_nwe_s));
  fsmc_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .reset_l(reset_l), .d(ncs), .q(w_ncs_s));

  // Same depth as the synchronisers, so the last stage is the sample taken
  // on the same edge as the synced strobe level.
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_addr_pipe;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_pipe;
  // One extra stage: edge detection compares synced level with its delayed
  // copy, and a write must capture the sample taken while nwe was still low.
  logic              r_noe_d, r_nwe_d;
  logic [ADDR_W-1:0] r_addr_d;
  logic [DATA_W-1:0] r_data_d;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_addr_pipe <= '0;
      r_data_pipe <= '0;
      r_noe_d     <= 1'b1;
      r_nwe_d     <= 1'b1;
      r_addr_d    <= '0;
      r_data_d    <= '0;
    end else begin
      r_addr_pipe <= {r_addr_pipe[SYNC_STAGES-2:0], addr};
      r_data_pipe <= {r_data_pipe[SYNC_STAGES-2:0], data};
      r_noe_d     <= w_noe_s;
      r_nwe_d     <= w_nwe_s;
      r_addr_d    <= r_addr_pipe[SYNC_STAGES-1];
      r_data_d    <= r_data_pipe[SYNC_STAGES-1];
    end
  end

  logic w_sel, w_noe_fall, w_nwe_fall, w_nwe_rise, w_both_low;

  assign w_sel      = ~w_ncs_s;
  assign w_noe_fall =  r_noe_d & ~w_noe_s;
  assign w_nwe_fall =  r_nwe_d & ~w_nwe_s;
  assign w_nwe_rise = ~r_nwe_d &  w_nwe_s;
  assign w_both_low =  w_sel & ~w_noe_s & ~w_nwe_s;

  // --------------------------------------------------------------------------
  // Bus-cycle FSM
  // --------------------------------------------------------------------------
  fsmc_state_t       r_state;
  logic              r_wr_stb, r_rd_req, r_err_stb;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [TMO_W-1:0]  r_tmo;
  // Set after a both-low violation; no new cycle is accepted until both
  // strobes have been seen high again.
  logic              r_block;
  logic              w_tmo_hit;

  assign w_tmo_hit = (r_tmo == TMO_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state   <= ST_IDLE;
      r_wr_stb  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_err_stb <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
      r_tmo     <= '0;
      r_block   <= 1'b0;
    end else begin
      r_wr_stb  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_err_stb <= 1'b0;
      if (w_both_low && !r_block) begin
        r_err_stb <= 1'b1;
        r_block   <= 1'b1;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_block) begin
              if (w_noe_s && w_nwe_s) r_block <= 1'b0;
            end else if (w_sel && w_nwe_fall && w_noe_s) begin
              r_state <= ST_WR;
            end else if (w_sel && w_noe_fall && w_nwe_s) begin
              r_state   <= ST_RD_WAIT;
              r_rd_req  <= 1'b1;
              r_rd_addr <= r_addr_pipe[SYNC_STAGES-1];
              r_tmo     <= '0;
            end
          end
          ST_WR: begin
            if (!w_sel) begin
              r_state <= ST_IDLE;
            end else if (w_nwe_rise) begin
              r_state   <= ST_IDLE;
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_addr_d;
              r_wr_data <= r_data_d;
            end
          end
          ST_RD_WAIT: begin
            if (dn.rd_ack) begin
              r_state <= ST_RD_DRIVE;
            end else if (!w_sel || w_noe_s) begin
              r_state   <= ST_IDLE;
              r_err_stb <= 1'b1;
            end else if (w_tmo_hit) begin
              r_state   <= ST_ERR;
              r_err_stb <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          ST_RD_DRIVE, ST_ERR: begin
            if (!w_sel || w_noe_s) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Read-data latch: only observed while driving, so it needs no reset.
  logic [DATA_W-1:0] r_latch;

  always_ff @(posedge clk) begin
    if (r_state == ST_RD_WAIT) begin
      if (dn.rd_ack) begin
        r_latch <= dn.rd_data;
      end else if (w_sel && !w_noe_s && w_tmo_hit) begin
        r_latch <= DATA_W'(FSMC_ERR_WORD);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tristate bus and outputs
  // --------------------------------------------------------------------------
  logic w_drive;

  assign w_drive = ((r_state == ST_RD_DRIVE) || (r_state == ST_ERR)) &&
                   w_sel && !w_noe_s;
  assign data    = w_drive ? r_latch : {DATA_W{1'bz}};

  assign dn.wr_stb  = r_wr_stb;
  assign dn.wr_addr = r_wr_addr;
  assign dn.wr_data = r_wr_data;
  assign dn.rd_req  = r_rd_req;
  assign dn.rd_addr = r_rd_addr;
  assign busy       = (r_state != ST_IDLE);
  assign err_stb    = r_err_stb;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef FSMC_STATS_EN
  logic [15:0] r_wr_cnt, r_rd_cnt, r_err_cnt;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_wr_stb)  r_wr_cnt  <= r_wr_cnt  + 16'd1;
      if (r_rd_req)  r_rd_cnt  <= r_rd_cnt  + 16'd1;
      if (r_err_stb) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign wr_cnt  = r_wr_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign err_cnt = r_err_cnt;
`else
  assign wr_cnt  = '0;
  assign rd_cnt  = '0;
  assign err_cnt = '0;
`endif

endmodule : fsmc_bus_frontend

`default_nettype wire

// File: tb/tb_fsmc_bus_frontend.sv
// ============================================================================
// Module      : tb_fsmc_bus_frontend
// Description : Self-checking bench for fsmc_bus_frontend. Expected write,
//               read-request and error events are queued as stimulus is
//               driven and popped by a monitor when the DUT strobes. The bench
//               holds the data bus at 16'h0000 whenever the DUT must not
//               drive, so any stray DUT drive shows up as a changed/X value.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fsmc_bus_frontend;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int RD_TIMEOUT  = 8;
`ifdef FSMC_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clk     = 1'b0;
  logic              reset_l = 1'b0;
  logic              noe     = 1'b1;
  logic              nwe     = 1'b1;
  logic              ncs     = 1'b1;
  logic [ADDR_W-1:0] addr    = '0;
  logic              tb_drv  = 1'b1;
  logic [DATA_W-1:0] tb_data = '0;
  wire  [DATA_W-1:0] data;
  logic              busy, err_stb;
  logic [15:0]       wr_cnt, rd_cnt, err_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int n_wr  = 0;
  int n_rd  = 0;
  int n_err = 0;

  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [ADDR_W-1:0]        rd_q[$];
  int                       err_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_w;
  logic [ADDR_W-1:0]        mon_a;
  int                       mon_e;

  fsmc_bus_frontend_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  assign data = tb_drv ? tb_data : {DATA_W{1'bz}};

  fsmc_bus_frontend #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SYNC_STAGES(SYNC_STAGES), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .noe(noe), .nwe(nwe), .ncs(ncs), .addr(addr), .data(data),
    .dn(bus.master),
    .busy(busy), .err_stb(err_stb),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a strobe
  always @(negedge clk) begin
    if (reset_l) begin
      if (bus.wr_stb) begin
        chk("wr_rd_overlap", {31'd0, bus.rd_req}, 0);
        if (wr_q.size() == 0) chk("wr_spurious", {31'd0, bus.wr_stb}, 0);
        else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", {30'd0, bus.wr_addr}, {30'd0, mon_w[ADDR_W+DATA_W-1:DATA_W]});
          chk("wr_data", {16'd0, bus.wr_data}, {16'd0, mon_w[DATA_W-1:0]});
        end
      end
      if (bus.rd_req) begin
        if (rd_q.size() == 0) chk("rd_spurious", {31'd0, bus.rd_req}, 0);
        else begin
          mon_a = rd_q.pop_front();
          chk("rd_addr", {30'd0, bus.rd_addr}, {30'd0, mon_a});
        end
      end
      if (err_stb) begin
        if (err_q.size() == 0) chk("err_spurious", {31'd0, err_stb}, 0);
        else mon_e = err_q.pop_front();
      end
    end
  end

  task automatic wait_rd_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rd_req) begin
        ok = 1'b1;
        return;
      end
    end
    chk("rd_req_wait", {31'd0, bus.rd_req}, 1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_q.push_back({a, d});
    n_wr++;
    addr = a; tb_data = d; tb_drv = 1'b1; ncs = 1'b0;
    repeat (3) step();
    nwe = 1'b0;
    repeat (6) step();
    nwe = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      step();
      chk("wr_stb_latency", {31'd0, bus.wr_stb}, {31'd0, (k == SYNC_STAGES + 1)});
    end
    ncs = 1'b1; tb_data = '0;
    repeat (2) step();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int ack_dly);
    bit ok;
    rd_q.push_back(a);
    n_rd++;
    addr = a; ncs = 1'b0; tb_drv = 1'b0;
    repeat (3) step();
    noe = 1'b0;
    wait_rd_req(ok);
    if (ok) begin
      repeat (ack_dly - 1) step();
      bus.rd_data = d; bus.rd_ack = 1'b1;
      step();
      bus.rd_ack = 1'b0; bus.rd_data = '0;
      chk("rd_drive", {16'd0, data}, {16'd0, d});
      repeat (2) step();
      chk("rd_drive_hold", {16'd0, data}, {16'd0, d});
    end
    noe = 1'b1; tb_drv = 1'b1; tb_data = '0;
    repeat (SYNC_STAGES + 1) step();
    chk("rd_release", {16'd0, data}, 0);
    chk("rd_busy_done", {31'd0, busy}, 0);
    ncs = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    bit ok;
    bus.rd_ack  = 1'b0;
    bus.rd_data = '0;

    // Reset state
    repeat (3) step();
    chk("rst_busy",    {31'd0, busy}, 0);
    chk("rst_wr_stb",  {31'd0, bus.wr_stb}, 0);
    chk("rst_rd_req",  {31'd0, bus.rd_req}, 0);
    chk("rst_err_stb", {31'd0, err_stb}, 0);
    chk("rst_wr_data", {16'd0, bus.wr_data}, 0);
    chk("rst_rd_addr", {30'd0, bus.rd_addr}, 0);
    chk("rst_data_z",  {16'd0, data}, 0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 0);
    reset_l = 1'b1;
    repeat (4) step();

    // Writes, two patterns
    do_write(2'd0, 16'h1234);
    do_write(2'd3, 16'hA5C3);

    // Read acked 3 clk after request
    do_read(2'd1, 16'hBEEF, 3);

    // Read timeout
    rd_q.push_back(2'd2); n_rd++;
    err_q.push_back(1);   n_err++;
    addr = 2'd2; ncs = 1'b0; tb_drv = 1'b0;
    repeat (3) step();
    noe = 1'b0;
    wait_rd_req(ok);
    for (int k = 1; k <= RD_TIMEOUT; k++) begin
      step();
      chk("tmo_err_stb", {31'd0, err_stb}, {31'd0, (k == RD_TIMEOUT)});
    end
    chk("tmo_data", {16'd0, data}, 32'h0000DEAD);
    chk("tmo_busy", {31'd0, busy}, 1);
    step();
    chk("tmo_err_cnt", {16'd0, err_cnt}, STATS);
    noe = 1'b1; tb_drv = 1'b1; tb_data = '0;
    repeat (SYNC_STAGES + 1) step();
    chk("tmo_release", {16'd0, data}, 0);
    ncs = 1'b1;
    repeat (2) step();

    // Read aborted by noe rising before ack; late ack must be ignored
    rd_q.push_back(2'd0); n_rd++;
    err_q.push_back(2);   n_err++;
    addr = 2'd0; ncs = 1'b0;
    repeat (3) step();
    noe = 1'b0;
    wait_rd_req(ok);
    noe = 1'b1;
    repeat (SYNC_STAGES + 2) step();
    bus.rd_data = 16'h7777; bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0; bus.rd_data = '0;
    step();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_data_z", {16'd0, data}, 0);
    ncs = 1'b1;
    repeat (2) step();

    // noe and nwe low together
    err_q.push_back(3); n_err++;
    ncs = 1'b0;
    repeat (3) step();
    noe = 1'b0; nwe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 3 || k == 7) chk("both_data_z", {16'd0, data}, 0);
    end
    chk("both_busy", {31'd0, busy}, 0);
    noe = 1'b1; nwe = 1'b1;
    repeat (4) step();
    ncs = 1'b1;
    repeat (3) step();

    // Deselected activity
    for (int i = 0; i < 6; i++) begin
      noe = i[0]; nwe = ~i[1];
      repeat (3) step();
      chk("desel_data_z", {16'd0, data}, 0);
      chk("desel_busy", {31'd0, busy}, 0);
    end
    noe = 1'b1; nwe = 1'b1;
    repeat (4) step();

    // Async reset while driving read data
    rd_q.push_back(2'd1); n_rd++;
    addr = 2'd1; ncs = 1'b0; tb_drv = 1'b0;
    repeat (3) step();
    noe = 1'b0;
    wait_rd_req(ok);
    bus.rd_data = 16'h5A5A; bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0; bus.rd_data = '0;
    chk("rst_mid_drive", {16'd0, data}, 32'h00005A5A);
    reset_l = 1'b0; tb_drv = 1'b1; tb_data = '0;
    #1;
    chk("rst_mid_data_z", {16'd0, data}, 0);
    chk("rst_mid_busy",   {31'd0, busy}, 0);
    chk("rst_mid_rd_cnt", {16'd0, rd_cnt}, 0);
    chk("rst_mid_wr_cnt", {16'd0, wr_cnt}, 0);
    n_wr = 0; n_rd = 0; n_err = 0;
    noe = 1'b1; ncs = 1'b1;
    repeat (3) step();
    reset_l = 1'b1;
    repeat (3) step();
    do_read(2'd3, 16'h0F0F, 2);

    // Scoreboard drained and statistics consistent
    repeat (3) step();
    chk("wr_q_left",  wr_q.size(), 0);
    chk("rd_q_left",  rd_q.size(), 0);
    chk("err_q_left", err_q.size(), 0);
    chk("end_wr_cnt",  {16'd0, wr_cnt},  STATS * n_wr);
    chk("end_rd_cnt",  {16'd0, rd_cnt},  STATS * n_rd);
    chk("end_err_cnt", {16'd0, err_cnt}, STATS * n_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fsmc_bus_frontend

`default_nettype wire
